// File: rtl/cordic_arb_pkg.sv
// ============================================================================
// Module      : cordic_arb_pkg
// Description : Shared types and constants for the cosine-unit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_arb_pkg;

    localparam int FLOAT_W         = 32;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker, search starts at last+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [NREQ-1:0]   w_mask;
    logic [2*NREQ-1:0] w_dbl;
    logic              w_found;

    // Lower half holds only requesters above last; upper half wraps around.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_mask[i] = (i > int'(last));
        end
        w_dbl        = {req, req & w_mask};
        w_found      = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int i = 0; i < 2*NREQ; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found   = 1'b1;
                grant_idx = (i < NREQ) ? IDW'(i) : IDW'(i - NREQ);
            end
        end
        if (w_found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/cordic_arbiter.sv
// ============================================================================
// Module      : cordic_arbiter
// Description : Round-robin sharing of one cosine unit with a watchdog abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*FLOAT_W-1:0] req_theta,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [FLOAT_W-1:0]      rsp_data,
    output logic                    rsp_err,
    output logic                    core_start,
    output logic [FLOAT_W-1:0]      core_theta,
    input  logic                    core_done,
    input  logic [FLOAT_W-1:0]      core_result
);

    localparam int             CW          = $clog2(TIMEOUT);
    localparam logic [IDW-1:0] c_last_init = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  c_cnt_max   = CW'(TIMEOUT - 1);

    state_t               r_state;
    logic [IDW-1:0]       r_last_grant;
    logic [IDW-1:0]       r_cur_id;
    logic [CW-1:0]        r_count;
    logic [FLOAT_W-1:0]   r_core_theta;
    logic                 r_rsp_valid;
    logic [IDW-1:0]       r_rsp_id;
    logic [FLOAT_W-1:0]   r_rsp_data;
    logic                 r_rsp_err;

    logic [NREQ-1:0]      w_grant_onehot;
    logic [IDW-1:0]       w_grant_idx;
    logic                 w_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req          (req_valid),
        .last         (r_last_grant),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx),
        .any          (w_any)
    );

    // Accept and start are qualified by clk_en so neither fires on a frozen cycle.
    assign req_ready  = (r_state == IDLE && clk_en) ? w_grant_onehot : '0;
    assign core_start = (r_state == START) && clk_en;
    assign core_theta = r_core_theta;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= c_last_init;
            r_cur_id     <= '0;
            r_count      <= '0;
            r_core_theta <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_core_theta <= req_theta[FLOAT_W*int'(w_grant_idx) +: FLOAT_W];
                        r_cur_id     <= w_grant_idx;
                        r_state      <= START;
                    end
                end
                START: begin
                    r_count <= '0;
                    r_state <= BUSY;
                end
                BUSY: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (core_done) begin
                        r_rsp_data  <= core_result;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_cur_id;
                        r_state     <= RESP;
                    end else if (r_count == c_cnt_max) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_cur_id;
                        r_state     <= RESP;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_last_grant <= r_cur_id;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
// ============================================================================
// Module      : tb_cordic_arbiter
// Description : Directed self-checking bench for cordic_arbiter with a core model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_arbiter;
    import cordic_arb_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_en;
    logic [3:0]   req_valid;
    logic [127:0] req_theta;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         core_start;
    logic [31:0]  core_theta;
    logic         core_done;
    logic [31:0]  core_result;

    int vectors     = 0;
    int miscompares = 0;
    int m_lat       = 0;
    int m_cnt       = 0;

    cordic_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .req_valid   (req_valid),
        .req_theta   (req_theta),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .core_start  (core_start),
        .core_theta  (core_theta),
        .core_done   (core_done),
        .core_result (core_result)
    );

    always #5 clk = ~clk;

    // Cosine unit model: done is seen m_lat enabled cycles after start (0 = never).
    always @(posedge clk) begin
        if (reset) m_cnt <= 0;
        else if (clk_en) begin
            if (core_start) m_cnt <= m_lat;
            else if (m_cnt > 0) m_cnt <= m_cnt - 1;
        end
    end
    assign core_done = (m_cnt == 1);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clk_en = 1'b1; req_valid = '0; rsp_ready = 1'b0; m_lat = 0;
        req_theta = {32'hC0400000, 32'h40000000, 32'h3FC00000, 32'h00000000};
        core_result = '0;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 400) begin
            cyc(); #1; n++;
        end
    endtask

    task automatic drain();
        int n;
        wait_rsp(n);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0; #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vectors++; if ({rsp_valid, rsp_err} !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_flags: got %b want 00", {rsp_valid, rsp_err}); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        vectors++; if (rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        vectors++; if ({core_start, core_theta} !== 33'h0) begin miscompares++; $display("FAIL reset_core: got %h want 0", {core_start, core_theta}); end
    endtask

    task automatic test_single();
        int t;
        core_result = 32'h3F800000; m_lat = 20;
        cyc(); req_valid = 4'b0001; #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_accept: got %b want 0001", req_ready); end
        cyc(); req_valid = 4'b0000; #1;
        vectors++; if (core_start !== 1'b1) begin miscompares++; $display("FAIL single_start: got %b want 1", core_start); end
        cyc(); #1;
        vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL single_start_width: got %b want 0", core_start); end
        t = 2;
        while (!rsp_valid && t < 300) begin cyc(); #1; t++; end
        vectors++; if (t !== 22) begin miscompares++; $display("FAIL single_latency: got %0d want 22", t); end
        vectors++; if ({rsp_id, rsp_data, rsp_err} !== {2'd0, 32'h3F800000, 1'b0})
            begin miscompares++; $display("FAIL single_rsp: got id=%0d data=%h err=%b want id=0 data=3f800000 err=0", rsp_id, rsp_data, rsp_err); end
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0; #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_rsp_clear: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [31:0] exp_th  [5] = '{32'h00000000, 32'h3FC00000, 32'h40000000, 32'hC0400000, 32'h00000000};
        int ng = 0;
        int n  = 0;
        do_reset();
        m_lat = 3; core_result = 32'h3F000000;
        req_valid = 4'b1111; rsp_ready = 1'b1;
        while (ng < 5 && n < 300) begin
            #1;
            if (req_ready !== 4'b0000) begin
                vectors++; if (req_ready !== exp_gnt[ng]) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", ng, req_ready, exp_gnt[ng]); end
                cyc(); n++; #1;
                vectors++; if (core_theta !== exp_th[ng]) begin miscompares++; $display("FAIL rr_theta%0d: got %h want %h", ng, core_theta, exp_th[ng]); end
                ng++;
            end
            cyc(); n++;
        end
        vectors++; if (ng !== 5) begin miscompares++; $display("FAIL rr_count: got %0d grants want 5", ng); end
        req_valid = 4'b0000;
        drain();
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        m_lat = 2; core_result = 32'h3F000000;
        req_valid = 4'b0011; rsp_ready = 1'b0;
        cyc();
        wait_rsp(n);
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_rsp_timeout: got %b want 1", rsp_valid); end
        core_result = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready} !== {1'b1, 2'd0, 32'h3F000000, 1'b0, 4'b0000}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d d=%h e=%b rr=%b want v=1 id=0 d=3f000000 e=0 rr=0000",
                         i, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready);
            end
        end
        rsp_ready = 1'b1;
        cyc(); rsp_ready = 1'b0; #1;
        vectors++; if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin miscompares++; $display("FAIL bp_next_grant: got v=%b rr=%b want v=0 rr=0010", rsp_valid, req_ready); end
        cyc(); req_valid = 4'b0000;
        drain();
    endtask

    task automatic test_watchdog();
        int t;
        m_lat = 0; core_result = 32'hDEADBEEF;
        cyc(); req_valid = 4'b0100; #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL wd_accept: got %b want 0100", req_ready); end
        cyc(); req_valid = 4'b0000; t = 1;
        while (!rsp_valid && t < 300) begin cyc(); #1; t++; end
        vectors++; if (t !== 66) begin miscompares++; $display("FAIL wd_latency: got %0d want 66", t); end
        vectors++; if ({rsp_id, rsp_data, rsp_err} !== {2'd2, 32'h0, 1'b1})
            begin miscompares++; $display("FAIL wd_rsp: got id=%0d data=%h err=%b want id=2 data=0 err=1", rsp_id, rsp_data, rsp_err); end
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
        // done lands on the final watchdog cycle
        m_lat = 64; core_result = 32'h3F3504F3;
        req_valid = 4'b0100; #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL wdc_accept: got %b want 0100", req_ready); end
        cyc(); req_valid = 4'b0000; t = 1;
        while (!rsp_valid && t < 300) begin cyc(); #1; t++; end
        vectors++; if (t !== 66) begin miscompares++; $display("FAIL wdc_latency: got %0d want 66", t); end
        vectors++; if ({rsp_data, rsp_err} !== {32'h3F3504F3, 1'b0})
            begin miscompares++; $display("FAIL wdc_rsp: got data=%h err=%b want data=3f3504f3 err=0", rsp_data, rsp_err); end
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    endtask

    task automatic test_clk_en();
        int a  = -1;
        int t  = 0;
        int nd = 0;
        int ns = 0;
        do_reset();
        m_lat = 20; core_result = 32'h3E800000;
        req_theta[31:0] = 32'h40490FDB;
        req_valid = 4'b0001; clk_en = 1'b0; #1;
        while (!rsp_valid && t < 400) begin
            if (!clk_en) begin
                vectors++; if ({req_ready, core_start} !== 5'b0) begin miscompares++; $display("FAIL ce_gated%0d: got rr=%b start=%b want 0", t, req_ready, core_start); end
            end
            if (a < 0 && req_ready !== 4'b0000) begin
                a = t;
                vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL ce_accept: got %b want 0001", req_ready); end
            end
            if (core_start === 1'b1) ns++;
            if (a >= 0 && t > a && !clk_en) nd++;
            cyc(); t++;
            clk_en = ~clk_en;
            if (a >= 0) req_valid = 4'b0000;
            #1;
        end
        vectors++; if (a < 0 || (t - a) !== 22 + nd) begin miscompares++; $display("FAIL ce_latency: got %0d want %0d", t - a, 22 + nd); end
        vectors++; if (ns !== 1) begin miscompares++; $display("FAIL ce_start_width: got %0d want 1", ns); end
        vectors++; if ({rsp_data, core_theta} !== {32'h3E800000, 32'h40490FDB})
            begin miscompares++; $display("FAIL ce_data: got data=%h theta=%h want 3e800000 40490fdb", rsp_data, core_theta); end
        clk_en = 1'b0; rsp_ready = 1'b1;
        cyc(); #1;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL ce_freeze_resp: got %b want 1", rsp_valid); end
        clk_en = 1'b1;
        cyc(); rsp_ready = 1'b0; #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ce_release_resp: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen = 0;
        do_reset();
        m_lat = 0; core_result = 32'hAAAAAAAA;
        req_valid = 4'b0010; #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL rm_accept: got %b want 0010", req_ready); end
        cyc(); req_valid = 4'b0000;
        repeat (5) cyc();
        reset = 1'b1; cyc(); reset = 1'b0; #1;
        vectors++; if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_start, core_theta} !== 73'h0)
            begin miscompares++; $display("FAIL rm_busy_reset: got %h want 0", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_start, core_theta}); end
        m_lat = 2; req_valid = 4'b0010;
        cyc(); req_valid = 4'b0000;
        wait_rsp(n);
        vectors++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd1}) begin miscompares++; $display("FAIL rm_resp_reach: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); end
        reset = 1'b1; cyc(); reset = 1'b0; #1;
        vectors++; if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_start, core_theta} !== 73'h0)
            begin miscompares++; $display("FAIL rm_resp_reset: got %h want 0", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_start, core_theta}); end
        repeat (30) begin cyc(); if (rsp_valid === 1'b1) seen = 1; end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rm_no_response: got %0d want 0", seen); end
        req_valid = 4'b0011; #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rm_next_grant: got %b want 0001", req_ready); end
        cyc(); req_valid = 4'b0000;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_watchdog();
        test_clk_en();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one `cosine` unit among `NREQ` requesters. Each requester has an independent valid/ready request channel carrying an IEEE-754 single-precision angle. The block grants requesters round-robin, sequences the unit's `start`/`done` handshake, and returns each result on a shared response channel tagged with the requester index. A watchdog aborts a stalled operation. The block sits between the host-facing request ports and the single `cosine` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(NREQ)`: width of the requester index.
- `TIMEOUT`, 64: maximum cycles spent in BUSY before abort, ≥ 2.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `clk_en` in 1: global clock enable. When low, every register holds its value.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_theta` in NREQ*32: angle for requester i at bits [32i+31:32i].
- `req_ready` out NREQ: one-hot accept strobe.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_id` out IDW: index of the requester that owns the response.
- `rsp_data` out 32: cosine result as a float.
- `rsp_err` out 1: 1 when the operation timed out. `rsp_data` is 0 in that case.
- `core_start` out 1: one-cycle start pulse to `cosine`.
- `core_theta` out 32: registered angle driven to `cosine`.
- `core_done` in 1: done from `cosine`.
- `core_result` in 32: result from `cosine`.

## Operation
- The FSM has four states: IDLE, START, BUSY, RESP.
- **IDLE**
  - If `clk_en` is high and any `req_valid` is set, pick grant g round-robin, searching from `last_grant+1` modulo NREQ.
  - Assert `req_ready[g]` combinationally in that cycle.
  - Register `core_theta <= req_theta[g]` and `cur_id <= g`, then go to START.
  - `req_ready` is all zero in every other state, and whenever `clk_en` is low.
- **START**
  - `core_start=1` for exactly one enabled cycle.
  - Clear the watchdog counter, then go to BUSY.
- **BUSY**
  - The counter increments each enabled cycle.
  - If `core_done` is high: latch `core_result` into `rsp_data`, set `rsp_err=0`, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT-1: set `rsp_data=0`, set `rsp_err=1`, go to RESP.
  - If `core_done` and the timeout occur in the same cycle, `core_done` wins.
- **RESP**
  - `rsp_valid=1` and `rsp_id=cur_id`.
  - When `rsp_ready` is high (and `clk_en` is high): set `last_grant <= cur_id` and go to IDLE.
  - `rsp_valid`, `rsp_id`, `rsp_data` and `rsp_err` stay stable while waiting.
- `core_done` is ignored outside BUSY. A done that is stale or arrives late is dropped.
- A requester that deasserts `req_valid` before it is granted is simply skipped. There is no penalty.
- The granted requester is excluded until every other active requester has been served once. This is the fairness guarantee.
- **Reset values:**
  - state IDLE
  - `last_grant = NREQ-1`, so requester 0 has first priority
  - `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `rsp_err` 0
  - `core_start` 0, `core_theta` 0, counter 0
- **Reset mid-operation:** any in-flight result is discarded and no response is issued. The parent resets the `cosine` unit with the same `reset`.

## Timing
- Cycle 0 is the accept (`req_ready[g]=1`).
- Cycle 1: `core_start=1`.
- Cycles 2..: BUSY.
- If `core_done` is first seen at cycle k, `rsp_valid` rises at cycle k+1.
- Total latency from accept to `rsp_valid` is core latency + 2 cycles, counted with `clk_en` high throughout.
- Back-to-back operation: `rsp_ready` at cycle n puts the FSM in IDLE at n+1, so the next accept is possible at cycle n+1.
- Only one operation is in flight at a time. There is no pipelining across requesters.
- Low `clk_en` stretches every phase by the number of disabled cycles. `core_start` is never asserted while `clk_en` is low.

## Structure
- Package `cordic_arb_pkg`:
  - `state_t` enum (IDLE, START, BUSY, RESP)
  - `FLOAT_W = 32`
  - `DEFAULT_TIMEOUT = 64`
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: `req[NREQ]`, `last[IDW]`.
  - Outputs: `grant_onehot[NREQ]`, `grant_idx[IDW]`, `any`.
  - Implemented as a double-width priority mask.
- The top level holds only the FSM, the registers and the watchdog counter.

## Test plan
- **Single request:** after reset, `req_valid=4'b0001` with θ=0x00000000, and a core model with latency 20 returning 0x3F800000. Expect `req_ready[0]` at cycle 0, `core_start` at cycle 1, and `rsp_valid` at cycle 22 with `rsp_id=0`, `rsp_data=0x3F800000`, `rsp_err=0`.
- **All requesters active:** hold `req_valid=4'b1111` and `rsp_ready=1`. Grants must come in order 0,1,2,3,0, with no requester granted twice before all four have been granted.
- **Response backpressure:** hold `rsp_ready=0` for 10 cycles. `rsp_*` must stay stable and `req_ready` must stay 0. When `rsp_ready=1`, expect the next grant one cycle later.
- **Watchdog:** the core never asserts done, with TIMEOUT=64. Expect `rsp_valid` with `rsp_err=1` and `rsp_data=0` exactly 64 BUSY cycles after START. Also test `core_done` and the timeout together: `rsp_err` must be 0.
- **Clock enable:** toggle `clk_en` 50% during every state. Outputs must freeze, `core_start` must stay one enabled cycle wide, and latency must grow by exactly the number of disabled cycles.
- **Reset mid-operation:** assert `reset` during BUSY and then during RESP. No response is produced, all outputs return to their reset values the next cycle, and the next grant goes to requester 0.
